// File: rtl/jk_count_ctrl_pkg.sv
// Shared definitions for the JK counter controller: command opcodes and FSM states.
package jk_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Command handshake bundle between the control source (master) and jk_count_ctrl (slave).
interface jk_count_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [WIDTH-1:0] CMD_DATA;
    logic [CNT_W-1:0] CMD_STEPS;

    modport master (output CMD_VALID, output CMD_OP, output CMD_DATA, output CMD_STEPS,
                    input  CMD_READY);
    modport slave  (input  CMD_VALID, input  CMD_OP, input  CMD_DATA, input  CMD_STEPS,
                    output CMD_READY);
endinterface

// File: rtl/jk_count_ctrl_ff_cell.sv
// Behavioural positive-edge JK flip-flop with asynchronous active-low clear.
module jk_ff_cell (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    logic q_q;

    // JK characteristic: set on J, reset on K, toggle on both, hold on neither.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= (j_i & ~q_q) | (~k_i & q_q);
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/jk_count_ctrl.sv
// Command sequencer driving a bank of JK flip-flops (load / count up / count down).
// Macro JK_COUNT_WRAP_EN: counting wraps modulo 2^WIDTH; undefined, counts saturate and set SAT.
module jk_count_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLR_n,
    jk_count_ctrl_if.slave   cmd,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE,
    output logic             SAT
);
    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] tog_s;
    logic             carry_s;
    logic [WIDTH-1:0] j_s, k_s;

    // Ripple toggle mask; the final carry means this step would wrap the counter.
    always_comb begin
        carry_s = 1'b1;
        tog_s   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog_s[i] = carry_s;
            carry_s  = carry_s & ((op_q == OP_UP) ? Q[i] : ~Q[i]);
        end
    end

    // Controller state and captured-command registers.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state and J/K drive generation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        j_s     = '0;
        k_s     = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.CMD_VALID) begin
                    op_d   = cmd.CMD_OP;
                    data_d = cmd.CMD_DATA;
                    rem_d  = cmd.CMD_STEPS;
                    sat_d  = 1'b0;
                    case (cmd.CMD_OP)
                        OP_LOAD:       state_d = ST_LOAD;
                        OP_UP, OP_DOWN: begin
                            if (cmd.CMD_STEPS != '0) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        default:       state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                j_s     = data_q;
                k_s     = ~data_q;
                state_d = ST_DONE;
            end
            ST_RUN: begin
`ifdef JK_COUNT_WRAP_EN
                j_s   = tog_s;
                k_s   = tog_s;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
`else
                if (carry_s) begin
                    sat_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    j_s   = tog_s;
                    k_s   = tog_s;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        jk_ff_cell u_cell (
            .clk_i   (CLK),
            .clr_n_i (CLR_n),
            .j_i     (j_s[gi]),
            .k_i     (k_s[gi]),
            .q_o     (Q[gi])
        );
    end

    assign J             = j_s;
    assign K             = k_s;
    assign BUSY          = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign DONE          = (state_q == ST_DONE);
    assign SAT           = sat_q;
    assign cmd.CMD_READY = (state_q == ST_IDLE);
endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed self-checking bench for jk_count_ctrl; expectations follow the JK_COUNT_WRAP_EN setting.
module tb_jk_count_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             CLR_n;
    logic [WIDTH-1:0] Q, J, K;
    logic             BUSY, DONE, SAT;
    int               checks;
    int               failures;

    jk_count_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    jk_count_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .CLR_n (CLR_n),
        .cmd   (cmd_if.slave),
        .Q     (Q),
        .J     (J),
        .K     (K),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SAT   (SAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a command in IDLE; returns just after the acceptance edge t0.
    task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_DATA  = data;
        cmd_if.CMD_STEPS = steps;
        tick();
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'b00;
        cmd_if.CMD_DATA  = 4'h0;
        cmd_if.CMD_STEPS = 8'd0;
    endtask

    task automatic do_load(input logic [3:0] data);
        issue(2'b01, data, 8'd0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        CLR_n = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'b00;
        cmd_if.CMD_DATA  = 4'h0;
        cmd_if.CMD_STEPS = 8'd0;
        tick();
        tick();
        checks++;
        if (Q !== 4'h0 || J !== 4'h0 || K !== 4'h0) begin
            failures++;
            $display("FAIL reset_qjk: Q=%h J=%h K=%h required 0/0/0", Q, J, K);
        end
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || SAT !== 1'b0 || cmd_if.CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: BUSY=%b DONE=%b SAT=%b READY=%b required 0 0 0 1",
                     BUSY, DONE, SAT, cmd_if.CMD_READY);
        end
        CLR_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        issue(2'b01, 4'hA, 8'd0);
        checks++;
        if (BUSY !== 1'b1 || cmd_if.CMD_READY !== 1'b0 || J !== 4'hA || K !== 4'h5 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL load_t0: BUSY=%b READY=%b J=%h K=%h DONE=%b required 1 0 a 5 0",
                     BUSY, cmd_if.CMD_READY, J, K, DONE);
        end
        tick();
        checks++;
        if (Q !== 4'hA || DONE !== 1'b1 || BUSY !== 1'b0 || J !== 4'h0 || K !== 4'h0) begin
            failures++;
            $display("FAIL load_t1: Q=%h DONE=%b BUSY=%b J=%h K=%h required a 1 0 0 0",
                     Q, DONE, BUSY, J, K);
        end
        tick();
        checks++;
        if (cmd_if.CMD_READY !== 1'b1 || DONE !== 1'b0 || Q !== 4'hA) begin
            failures++;
            $display("FAIL load_t2: READY=%b DONE=%b Q=%h required 1 0 a", cmd_if.CMD_READY, DONE, Q);
        end
    endtask

    task automatic test_up();
        do_load(4'h3);
        issue(2'b10, 4'h0, 8'd5);
        checks++;
        if (J !== 4'h7 || K !== 4'h7 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL up_jk: J=%h K=%h BUSY=%b required 7 7 1", J, K, BUSY);
        end
        for (int s = 1; s <= 5; s++) begin
            tick();
            checks++;
            if (Q !== 4'(3 + s) || DONE !== (s == 5) || cmd_if.CMD_READY !== 1'b0) begin
                failures++;
                $display("FAIL up_step%0d: Q=%h DONE=%b READY=%b required %h %b 0",
                         s, Q, DONE, cmd_if.CMD_READY, 4'(3 + s), (s == 5));
            end
        end
        tick();
        checks++;
        if (cmd_if.CMD_READY !== 1'b1 || DONE !== 1'b0 || Q !== 4'h8) begin
            failures++;
            $display("FAIL up_idle: READY=%b DONE=%b Q=%h required 1 0 8", cmd_if.CMD_READY, DONE, Q);
        end
    endtask

    task automatic test_down();
        logic [3:0] exp_q [3];
        logic [2:0] exp_done;
        logic       exp_sat;
`ifdef JK_COUNT_WRAP_EN
        exp_q    = '{4'h0, 4'hF, 4'hE};
        exp_done = 3'b100;
        exp_sat  = 1'b0;
`else
        exp_q    = '{4'h0, 4'h0, 4'h0};
        exp_done = 3'b010;
        exp_sat  = 1'b1;
`endif
        do_load(4'h1);
        issue(2'b11, 4'h0, 8'd3);
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (Q !== exp_q[s] || DONE !== exp_done[s]) begin
                failures++;
                $display("FAIL down_step%0d: Q=%h DONE=%b required %h %b", s + 1, Q, DONE, exp_q[s], exp_done[s]);
            end
`ifndef JK_COUNT_WRAP_EN
            if (s == 0) begin
                checks++;
                if (J !== 4'h0 || K !== 4'h0 || SAT !== 1'b0) begin
                    failures++;
                    $display("FAIL down_suppress: J=%h K=%h SAT=%b required 0 0 0", J, K, SAT);
                end
            end
`endif
        end
        checks++;
        if (SAT !== exp_sat) begin
            failures++;
            $display("FAIL down_sat: SAT=%b required %b", SAT, exp_sat);
        end
    endtask

    task automatic test_zero_steps();
        logic [3:0] q_exp;
`ifdef JK_COUNT_WRAP_EN
        q_exp = 4'hE;
`else
        q_exp = 4'h0;
`endif
        tick();
        checks++;
        if (cmd_if.CMD_READY !== 1'b1 || J !== 4'h0 || K !== 4'h0) begin
            failures++;
            $display("FAIL zero_idle: READY=%b J=%h K=%h required 1 0 0", cmd_if.CMD_READY, J, K);
        end
        for (int c = 0; c < 2; c++) begin
            if (c == 0) issue(2'b10, 4'h7, 8'd0);
            else        issue(2'b00, 4'h7, 8'd9);
            checks++;
            if (DONE !== 1'b1 || BUSY !== 1'b0 || Q !== q_exp || J !== 4'h0 || K !== 4'h0 || SAT !== 1'b0) begin
                failures++;
                $display("FAIL zero_cmd%0d: DONE=%b BUSY=%b Q=%h J=%h K=%h SAT=%b required 1 0 %h 0 0 0",
                         c, DONE, BUSY, Q, J, K, SAT, q_exp);
            end
            tick();
            checks++;
            if (cmd_if.CMD_READY !== 1'b1 || DONE !== 1'b0 || Q !== q_exp) begin
                failures++;
                $display("FAIL zero_back%0d: READY=%b DONE=%b Q=%h required 1 0 %h",
                         c, cmd_if.CMD_READY, DONE, Q, q_exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        do_load(4'h0);
        issue(2'b10, 4'h0, 8'd10);
        for (int s = 0; s < 4; s++) tick();
        checks++;
        if (Q !== 4'h4 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: Q=%h BUSY=%b required 4 1", Q, BUSY);
        end
        #2;
        CLR_n = 1'b0;
        #1;
        checks++;
        if (Q !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || cmd_if.CMD_READY !== 1'b1 || J !== 4'h0) begin
            failures++;
            $display("FAIL midrun_clr: Q=%h BUSY=%b DONE=%b READY=%b J=%h required 0 0 0 1 0",
                     Q, BUSY, DONE, cmd_if.CMD_READY, J);
        end
        tick();
        CLR_n = 1'b1;
        for (int s = 0; s < 12; s++) begin
            tick();
            if (DONE === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || Q !== 4'h0) begin
            failures++;
            $display("FAIL midrun_quiet: done_cycles=%0d Q=%h required 0 0", done_seen, Q);
        end
        issue(2'b01, 4'h5, 8'd0);
        tick();
        checks++;
        if (Q !== 4'h5 || DONE !== 1'b1) begin
            failures++;
            $display("FAIL midrun_load: Q=%h DONE=%b required 5 1", Q, DONE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int busy_cycles;
        busy_cycles = 0;
        do_load(4'h0);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = 2'b10;
        cmd_if.CMD_STEPS = 8'd2;
        cmd_if.CMD_DATA  = 4'h0;
        tick();
        cmd_if.CMD_OP    = 2'b01;
        cmd_if.CMD_DATA  = 4'h9;
        cmd_if.CMD_STEPS = 8'd7;
        tick();
        tick();
        checks++;
        if (Q !== 4'h2 || DONE !== 1'b1 || cmd_if.CMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL b2b_run: Q=%h DONE=%b READY=%b required 2 1 0", Q, DONE, cmd_if.CMD_READY);
        end
        tick();
        checks++;
        if (cmd_if.CMD_READY !== 1'b1 || BUSY !== 1'b0 || Q !== 4'h2) begin
            failures++;
            $display("FAIL b2b_idle: READY=%b BUSY=%b Q=%h required 1 0 2", cmd_if.CMD_READY, BUSY, Q);
        end
        tick();
        cmd_if.CMD_VALID = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || J !== 4'h9 || K !== 4'h6) begin
            failures++;
            $display("FAIL b2b_accept: BUSY=%b J=%h K=%h required 1 9 6", BUSY, J, K);
        end
        busy_cycles = 1;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (BUSY === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles !== 1 || Q !== 4'h9 || cmd_if.CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_once: busy_cycles=%0d Q=%h READY=%b required 1 9 1",
                     busy_cycles, Q, cmd_if.CMD_READY);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load();
        test_up();
        test_down();
        test_zero_steps();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
